mem_stage: RTL and testbench

- Memory-access pipeline stage (MS), directly downstream of the EX stage and upstream of WB.
- Latches the EX result bundle and waits for the data-SRAM response (data_ok) when EX issued a request.
- Buffers the response if WB stalls, aligns and extends load data, and forwards the write-back bundle to WB plus a bypass bundle to ID.
- Tracks responses orphaned by an exception flush and discards them.

---
 rtl/mem_stage_pkg.sv | 36 +++
 rtl/mem_stage_load_align.sv | 31 +++
 rtl/mem_stage.sv | 146 ++++++++++++++
 tb/tb_mem_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: load-op encoding, exception
// vector layout and write-back/bypass bundle widths.
package mem_stage_pkg;

  localparam int DATA_W    = 32;
  localparam int RF_ADDR_W = 5;
  localparam int LD_OP_W   = 5;
  localparam int MS_EXC_W  = 7;

  // es_ld_op is one-hot {ld_w, ld_h, ld_hu, ld_b, ld_bu}
  localparam int LD_BU = 0;
  localparam int LD_B  = 1;
  localparam int LD_HU = 2;
  localparam int LD_H  = 3;
  localparam int LD_W  = 4;

  localparam int EXC_INT  = 0;
  localparam int EXC_ADEF = 1;
  localparam int EXC_INE  = 2;
  localparam int EXC_SYS  = 3;
  localparam int EXC_BRK  = 4;
  localparam int EXC_RSV  = 5;
  localparam int EXC_ALE  = 6;

  typedef struct packed {
    logic [DATA_W-1:0]    pc;
    logic [DATA_W-1:0]    result;
    logic                 res_from_mem;
    logic                 mem_req;
    logic [LD_OP_W-1:0]   ld_op;
    logic                 rf_we;
    logic [RF_ADDR_W-1:0] rf_waddr;
    logic                 csr_re;
  } ms_bundle_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Extracts the addressed byte/halfword from a 32-bit read word and extends it
// according to the one-hot load opcode.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [DATA_W-1:0]  rdata,
  input  logic [1:0]         addr_lo,
  input  logic [LD_OP_W-1:0] ld_op,
  output logic [DATA_W-1:0]  wdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    wdata = rdata;
    if (ld_op[LD_B])       wdata = {{24{byte_v[7]}}, byte_v};
    else if (ld_op[LD_BU]) wdata = {24'd0, byte_v};
    else if (ld_op[LD_H])  wdata = {{16{half_v[15]}}, half_v};
    else if (ld_op[LD_HU]) wdata = {16'd0, half_v};
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds the EX bundle until its data-SRAM
// response arrives, buffers it across WB stalls and drops flushed responses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int EXC_W    = MS_EXC_W,
  parameter int CANCEL_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 es_to_ms_valid,
  output logic                 ms_allowin,
  input  logic [DATA_W-1:0]    es_pc,
  input  logic [DATA_W-1:0]    es_result,
  input  logic                 es_res_from_mem,
  input  logic                 es_mem_req,
  input  logic [LD_OP_W-1:0]   es_ld_op,
  input  logic                 es_rf_we,
  input  logic [RF_ADDR_W-1:0] es_rf_waddr,
  input  logic                 es_csr_re,
  input  logic [EXC_W-1:0]     es_except,
  input  logic                 data_sram_data_ok,
  input  logic [DATA_W-1:0]    data_sram_rdata,
  input  logic                 except_flush,
  input  logic                 ws_allowin,
  output logic                 ms_to_ws_valid,
  output logic [DATA_W-1:0]    ms_pc,
  output logic                 ms_rf_we,
  output logic [RF_ADDR_W-1:0] ms_rf_waddr,
  output logic [DATA_W-1:0]    ms_rf_wdata,
  output logic [EXC_W-1:0]     ms_except,
  output logic                 ms_ex,
  output logic                 ms_fwd_we,
  output logic [RF_ADDR_W-1:0] ms_fwd_waddr,
  output logic [DATA_W-1:0]    ms_fwd_wdata,
  output logic                 ms_ld_pending,
  output logic                 ms_csr_re
);

  localparam logic [CANCEL_W-1:0] CANCEL_MAX = '1;

  logic                ms_valid_q, ms_valid_d;
  ms_bundle_t          bundle_q, bundle_d;
  logic [EXC_W-1:0]    except_q, except_d;
  logic                data_buf_valid_q, data_buf_valid_d;
  logic [DATA_W-1:0]   data_buf_q, data_buf_d;
  logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;

  logic                data_ok_eff;
  logic                ms_ready_go;
  logic                cancel_inc;
  logic                cancel_dec;
  logic [DATA_W-1:0]   raw_rdata;
  logic [DATA_W-1:0]   aligned_data;

  // Responses arrive in order, so while discards are outstanding every
  // data_ok belongs to a flushed instruction.
  assign data_ok_eff    = data_sram_data_ok & (cancel_cnt_q == '0);
  assign ms_ready_go    = ~bundle_q.mem_req | data_ok_eff | data_buf_valid_q;
  assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;

  assign cancel_inc = except_flush & ms_valid_q & bundle_q.mem_req
                    & ~data_buf_valid_q & ~data_ok_eff;
  assign cancel_dec = data_sram_data_ok & (cancel_cnt_q != '0);

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (except_flush)    ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = es_to_ms_valid;

    bundle_d = bundle_q;
    except_d = except_q;
    if (es_to_ms_valid && ms_allowin) begin
      bundle_d.pc           = es_pc;
      bundle_d.result       = es_result;
      bundle_d.res_from_mem = es_res_from_mem;
      bundle_d.mem_req      = es_mem_req;
      bundle_d.ld_op        = es_ld_op;
      bundle_d.rf_we        = es_rf_we;
      bundle_d.rf_waddr     = es_rf_waddr;
      bundle_d.csr_re       = es_csr_re;
      except_d              = es_except;
    end
  end

  always_comb begin
    data_buf_valid_d = data_buf_valid_q;
    data_buf_d       = data_buf_q;
    if (except_flush || (ms_to_ws_valid && ws_allowin)) begin
      data_buf_valid_d = 1'b0;
    end else if (data_ok_eff && ms_valid_q && bundle_q.mem_req && !ws_allowin) begin
      data_buf_valid_d = 1'b1;
      data_buf_d       = data_sram_rdata;
    end
  end

  always_comb begin
    cancel_cnt_d = cancel_cnt_q;
    if (cancel_inc && !cancel_dec) begin
      if (cancel_cnt_q != CANCEL_MAX) cancel_cnt_d = cancel_cnt_q + 1'b1;
    end else if (cancel_dec && !cancel_inc) begin
      cancel_cnt_d = cancel_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q       <= 1'b0;
      bundle_q         <= '0;
      except_q         <= '0;
      data_buf_valid_q <= 1'b0;
      data_buf_q       <= '0;
      cancel_cnt_q     <= '0;
    end else begin
      ms_valid_q       <= ms_valid_d;
      bundle_q         <= bundle_d;
      except_q         <= except_d;
      data_buf_valid_q <= data_buf_valid_d;
      data_buf_q       <= data_buf_d;
      cancel_cnt_q     <= cancel_cnt_d;
    end
  end

  assign raw_rdata = data_buf_valid_q ? data_buf_q : data_sram_rdata;

  mem_stage_load_align u_load_align (
    .rdata   (raw_rdata),
    .addr_lo (bundle_q.result[1:0]),
    .ld_op   (bundle_q.ld_op),
    .wdata   (aligned_data)
  );

  assign ms_pc         = bundle_q.pc;
  assign ms_except     = except_q & {EXC_W{ms_valid_q}};
  assign ms_ex         = |ms_except;
  assign ms_rf_we      = ms_valid_q & bundle_q.rf_we & ~ms_ex;
  assign ms_rf_waddr   = bundle_q.rf_waddr;
  assign ms_rf_wdata   = bundle_q.res_from_mem ? aligned_data : bundle_q.result;
  assign ms_fwd_we     = ms_valid_q & bundle_q.rf_we;
  assign ms_fwd_waddr  = bundle_q.rf_waddr;
  assign ms_fwd_wdata  = ms_rf_wdata;
  assign ms_ld_pending = ms_valid_q & bundle_q.res_from_mem & ~ms_ready_go;
  assign ms_csr_re     = ms_valid_q & bundle_q.csr_re;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, load alignment,
// WB-stall buffering, flush discard/saturation and asynchronous reset.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [31:0] es_result;
  logic        es_res_from_mem;
  logic        es_mem_req;
  logic [4:0]  es_ld_op;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic        es_csr_re;
  logic [6:0]  es_except;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        except_flush;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic [6:0]  ms_except;
  logic        ms_ex;
  logic        ms_fwd_we;
  logic [4:0]  ms_fwd_waddr;
  logic [31:0] ms_fwd_wdata;
  logic        ms_ld_pending;
  logic        ms_csr_re;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  int xfer_base;

  mem_stage #(.EXC_W(7), .CANCEL_W(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allowin        (ms_allowin),
    .es_pc             (es_pc),
    .es_result         (es_result),
    .es_res_from_mem   (es_res_from_mem),
    .es_mem_req        (es_mem_req),
    .es_ld_op          (es_ld_op),
    .es_rf_we          (es_rf_we),
    .es_rf_waddr       (es_rf_waddr),
    .es_csr_re         (es_csr_re),
    .es_except         (es_except),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .except_flush      (except_flush),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_pc             (ms_pc),
    .ms_rf_we          (ms_rf_we),
    .ms_rf_waddr       (ms_rf_waddr),
    .ms_rf_wdata       (ms_rf_wdata),
    .ms_except         (ms_except),
    .ms_ex             (ms_ex),
    .ms_fwd_we         (ms_fwd_we),
    .ms_fwd_waddr      (ms_fwd_waddr),
    .ms_fwd_wdata      (ms_fwd_wdata),
    .ms_ld_pending     (ms_ld_pending),
    .ms_csr_re         (ms_csr_re)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ms_to_ws_valid && ws_allowin) xfers++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_es(input logic [31:0] pc, input logic [31:0] res,
                          input logic from_mem, input logic req, input logic [4:0] op,
                          input logic [4:0] wa, input logic [6:0] ex);
    es_to_ms_valid  = 1'b1;
    es_pc           = pc;
    es_result       = res;
    es_res_from_mem = from_mem;
    es_mem_req      = req;
    es_ld_op        = op;
    es_rf_we        = 1'b1;
    es_rf_waddr     = wa;
    es_csr_re       = 1'b0;
    es_except       = ex;
  endtask

  initial begin
    reset = 1'b1;
    es_to_ms_valid = 0; es_pc = 0; es_result = 0; es_res_from_mem = 0;
    es_mem_req = 0; es_ld_op = 0; es_rf_we = 0; es_rf_waddr = 0;
    es_csr_re = 0; es_except = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
    except_flush = 0; ws_allowin = 1;

    tick();
    chk("rst_allowin", 32'(ms_allowin), 32'd1);
    chk("rst_to_ws", 32'(ms_to_ws_valid), 32'd0);
    chk("rst_wdata", ms_rf_wdata, 32'd0);
    chk("rst_pc", ms_pc, 32'd0);
    reset = 1'b0;
    tick();

    // ALU pass-through
    drive_es(32'h100, 32'h12345678, 1'b0, 1'b0, 5'b00000, 5'd5, 7'd0);
    tick();
    es_to_ms_valid = 0;
    #1;
    chk("alu_to_ws", 32'(ms_to_ws_valid), 32'd1);
    chk("alu_wdata", ms_rf_wdata, 32'h12345678);
    chk("alu_we", 32'(ms_rf_we), 32'd1);
    chk("alu_waddr", 32'(ms_rf_waddr), 32'd5);
    chk("alu_pc", ms_pc, 32'h100);
    tick();
    chk("alu_gone", 32'(ms_to_ws_valid), 32'd0);

    // ld_b then ld_bu at 0x1003, data_ok two cycles after entry
    for (int k = 0; k < 2; k++) begin
      drive_es(32'h200, 32'h1003, 1'b1, 1'b1, (k == 0) ? 5'b00010 : 5'b00001, 5'd7, 7'd0);
      tick();
      es_to_ms_valid = 0;
      #1;
      chk("ldb_pend0", 32'(ms_ld_pending), 32'd1);
      chk("ldb_allow0", 32'(ms_allowin), 32'd0);
      tick();
      chk("ldb_pend1", 32'(ms_ld_pending), 32'd1);
      tick();
      data_sram_data_ok = 1; data_sram_rdata = 32'h80FF0000;
      #1;
      chk("ldb_pend2", 32'(ms_ld_pending), 32'd0);
      chk("ldb_to_ws", 32'(ms_to_ws_valid), 32'd1);
      chk("ldb_wdata", ms_rf_wdata, (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
      chk("ldb_fwd", ms_fwd_wdata, (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
      tick();
      data_sram_data_ok = 0;
      #1;
      chk("ldb_gone", 32'(ms_to_ws_valid), 32'd0);
    end

    // ld_h at 0x2002 with WB stalled for three cycles
    xfer_base = xfers;
    drive_es(32'h300, 32'h2002, 1'b1, 1'b1, 5'b01000, 5'd8, 7'd0);
    tick();
    es_to_ms_valid = 0;
    ws_allowin = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h80011234;
    #1;
    chk("ldh_to_ws", 32'(ms_to_ws_valid), 32'd1);
    chk("ldh_allow", 32'(ms_allowin), 32'd0);
    tick();
    data_sram_data_ok = 0; data_sram_rdata = 32'hAAAAAAAA;
    #1;
    chk("ldh_bufv", 32'(dut.data_buf_valid_q), 32'd1);
    chk("ldh_buf_wdata", ms_rf_wdata, 32'hFFFF8001);
    tick();
    tick();
    ws_allowin = 1;
    #1;
    chk("ldh_rel_wdata", ms_rf_wdata, 32'hFFFF8001);
    tick();
    chk("ldh_xfers", 32'(xfers - xfer_base), 32'd1);
    chk("ldh_bufv_clr", 32'(dut.data_buf_valid_q), 32'd0);
    chk("ldh_gone", 32'(ms_to_ws_valid), 32'd0);

    // flush a pending load, drop its orphaned response
    drive_es(32'h400, 32'h3000, 1'b1, 1'b1, 5'b10000, 5'd9, 7'd0);
    tick();
    es_to_ms_valid = 0;
    except_flush = 1;
    tick();
    except_flush = 0;
    #1;
    chk("fl_valid", 32'(ms_to_ws_valid | ms_ld_pending), 32'd0);
    chk("fl_cancel", 32'(dut.cancel_cnt_q), 32'd1);
    drive_es(32'h404, 32'h3004, 1'b1, 1'b1, 5'b10000, 5'd10, 7'd0);
    tick();
    es_to_ms_valid = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'h0000DEAD;
    #1;
    chk("fl_drop_to_ws", 32'(ms_to_ws_valid), 32'd0);
    chk("fl_drop_pend", 32'(ms_ld_pending), 32'd1);
    tick();
    data_sram_data_ok = 0;
    #1;
    chk("fl_cancel_drain", 32'(dut.cancel_cnt_q), 32'd0);
    tick();
    data_sram_data_ok = 1; data_sram_rdata = 32'h00BEEF00;
    #1;
    chk("fl_ld2_to_ws", 32'(ms_to_ws_valid), 32'd1);
    chk("fl_ld2_wdata", ms_rf_wdata, 32'h00BEEF00);
    tick();
    data_sram_data_ok = 0;

    // flush coinciding with data_ok consumes the response
    drive_es(32'h500, 32'h4000, 1'b1, 1'b1, 5'b10000, 5'd11, 7'd0);
    tick();
    es_to_ms_valid = 0;
    except_flush = 1; data_sram_data_ok = 1; data_sram_rdata = 32'h11111111;
    tick();
    except_flush = 0; data_sram_data_ok = 0;
    #1;
    chk("flok_cancel", 32'(dut.cancel_cnt_q), 32'd0);
    chk("flok_valid", 32'(ms_to_ws_valid), 32'd0);

    // excepting bundle passes through with write-back suppressed
    drive_es(32'h600, 32'h55AA55AA, 1'b0, 1'b0, 5'b00000, 5'd12, 7'h40);
    tick();
    es_to_ms_valid = 0;
    #1;
    chk("ex_ms_ex", 32'(ms_ex), 32'd1);
    chk("ex_rf_we", 32'(ms_rf_we), 32'd0);
    chk("ex_fwd_we", 32'(ms_fwd_we), 32'd1);
    chk("ex_except", 32'(ms_except), 32'h40);
    chk("ex_to_ws", 32'(ms_to_ws_valid), 32'd1);
    tick();
    chk("ex_gone_except", 32'(ms_except), 32'd0);

    // four flushed loads saturate the 2-bit discard counter at 3
    for (int i = 0; i < 4; i++) begin
      drive_es(32'h700 + 32'(i * 4), 32'h5000, 1'b1, 1'b1, 5'b10000, 5'd13, 7'd0);
      tick();
      es_to_ms_valid = 0;
      except_flush = 1;
      tick();
      except_flush = 0;
      #1;
      if (i == 1) chk("sat_cnt2", 32'(dut.cancel_cnt_q), 32'd2);
    end
    chk("sat_cnt3", 32'(dut.cancel_cnt_q), 32'd3);

    // asynchronous reset while a load waits behind discards
    drive_es(32'h800, 32'h6000, 1'b1, 1'b1, 5'b10000, 5'd14, 7'd0);
    tick();
    es_to_ms_valid = 0; ws_allowin = 0;
    #1;
    chk("rw_pend", 32'(ms_ld_pending), 32'd1);
    #2;
    reset = 1;
    #1;
    chk("rw_allowin", 32'(ms_allowin), 32'd1);
    chk("rw_cancel", 32'(dut.cancel_cnt_q), 32'd0);
    chk("rw_pend_clr", 32'(ms_ld_pending), 32'd0);
    chk("rw_pc", ms_pc, 32'd0);
    chk("rw_bufv", 32'(dut.data_buf_valid_q), 32'd0);
    tick();
    reset = 0; ws_allowin = 1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
